// File: rtl/matrix_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_mult_seq
// Purpose  : Sequential NxN matrix multiplier (C = A x B) built around one shared MAC.
// Revision : 1.0
// ============================================================================
module matrix_mult_seq #(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 2,
  parameter int SIGNED     = 0,
  localparam int OUT_WIDTH = 2*DATA_WIDTH + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NN = N*N;
  localparam int KW = $clog2(NN);
  localparam int IW = $clog2(N);
  localparam logic [KW-1:0] c_LAST = KW'(NN-1);
  localparam logic [IW-1:0] c_NM1  = IW'(N-1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         r_m;
  logic [IW-1:0]         r_i;
  logic [IW-1:0]         r_j;
  logic [IW-1:0]         r_p;
  logic [OUT_WIDTH-1:0]  r_acc;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [OUT_WIDTH-1:0]  r_out_data;

  logic [DATA_WIDTH-1:0] r_a [NN];
  logic [DATA_WIDTH-1:0] r_b [NN];
  logic [OUT_WIDTH-1:0]  r_c [NN];

  logic [KW-1:0]         w_aidx;
  logic [KW-1:0]         w_bidx;
  logic [KW-1:0]         w_cidx;
  logic [KW-1:0]         w_m_next;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [OUT_WIDTH-1:0]  w_a_ext;
  logic [OUT_WIDTH-1:0]  w_b_ext;
  logic [OUT_WIDTH-1:0]  w_prod;
  logic [OUT_WIDTH-1:0]  w_sum;
  logic                  w_load_fire;
  logic                  w_last_mac;

  always_comb begin
    w_aidx      = KW'(int'(r_i) * N + int'(r_p));
    w_bidx      = KW'(int'(r_p) * N + int'(r_j));
    w_cidx      = KW'(int'(r_i) * N + int'(r_j));
    w_m_next    = r_m + 1'b1;
    w_a         = r_a[w_aidx];
    w_b         = r_b[w_bidx];
    w_load_fire = (r_state == S_LOAD) && in_valid;
    w_last_mac  = (r_i == c_NM1) && (r_j == c_NM1) && (r_p == c_NM1);
  end

  // Low OUT_WIDTH bits of the extended product are exact in both signedness modes.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a_ext = {{(OUT_WIDTH-DATA_WIDTH){w_a[DATA_WIDTH-1]}}, w_a};
      assign w_b_ext = {{(OUT_WIDTH-DATA_WIDTH){w_b[DATA_WIDTH-1]}}, w_b};
    end else begin : g_unsigned
      assign w_a_ext = {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, w_a};
      assign w_b_ext = {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, w_b};
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;
  assign w_sum  = ((r_p == '0) ? '0 : r_acc) + w_prod;

  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_a[r_k] <= in_a;
      r_b[r_k] <= in_b;
    end
    if ((r_state == S_COMPUTE) && (r_p == c_NM1)) begin
      r_c[w_cidx] <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_k         <= '0;
      r_m         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_p         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_fire) begin
            if (r_k == c_LAST) begin
              r_k        <= '0;
              r_i        <= '0;
              r_j        <= '0;
              r_p        <= '0;
              r_state    <= S_COMPUTE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end

        S_COMPUTE: begin
          r_acc <= w_sum;
          if (w_last_mac) begin
            r_i     <= '0;
            r_j     <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_state <= S_DRAIN;
          end else if (r_p == c_NM1) begin
            r_p <= '0;
            if (r_j == c_NM1) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_p <= r_p + 1'b1;
          end
        end

        S_DRAIN: begin
          // First DRAIN cycle primes the output register from C[0].
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_c[r_m];
            r_out_last  <= (r_m == c_LAST);
          end else if (out_ready) begin
            if (r_m == c_LAST) begin
              r_m         <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_m        <= w_m_next;
              r_out_data <= r_c[w_m_next];
              r_out_last <= (w_m_next == c_LAST);
            end
          end
        end

        default: begin
          r_state    <= S_LOAD;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_mult_seq
// Purpose  : Self-checking bench for matrix_mult_seq, unsigned and signed instances side by side.
// Revision : 1.0
// ============================================================================
module tb_matrix_mult_seq;

  localparam int DW = 4;
  localparam int N  = 2;
  localparam int NN = N*N;
  localparam int OW = 2*DW + 1;

  typedef logic [NN-1:0][DW-1:0] mat_t;
  typedef logic [NN-1:0][OW-1:0] res_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
    res_t eu;
    res_t es;
  } vec_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_a      = '0;
  logic [DW-1:0] in_b      = '0;

  logic          rdy_u, rdy_s, ov_u, ov_s, ol_u, ol_s, bz_u, bz_s;
  logic [OW-1:0] od_u, od_s;

  int nchk = 0;
  int nerr = 0;

  matrix_mult_seq #(.DATA_WIDTH(DW), .N(N), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_u), .out_ready(out_ready),
    .out_data(od_u), .out_last(ol_u), .busy(bz_u)
  );

  matrix_mult_seq #(.DATA_WIDTH(DW), .N(N), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .out_last(ol_s), .busy(bz_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic mat_t mk4(input int x0, input int x1, input int x2, input int x3);
    mat_t r;
    r[0] = DW'(x0); r[1] = DW'(x1); r[2] = DW'(x2); r[3] = DW'(x3);
    return r;
  endfunction

  function automatic res_t mk9(input int x0, input int x1, input int x2, input int x3);
    res_t r;
    r[0] = OW'(x0); r[1] = OW'(x1); r[2] = OW'(x2); r[3] = OW'(x3);
    return r;
  endfunction

  // Reference: textbook row-by-column dot products in plain integer arithmetic.
  function automatic res_t model(input mat_t a, input mat_t b, input bit sgn);
    res_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int p = 0; p < N; p++) begin
          int x, y;
          if (sgn) begin
            x = int'($signed(a[i*N+p]));
            y = int'($signed(b[p*N+j]));
          end else begin
            x = int'(a[i*N+p]);
            y = int'(b[p*N+j]);
          end
          s += x * y;
        end
        r[i*N+j] = OW'(s);
      end
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, " in_ready_u"},  32'(rdy_u), 1);
    chk({tag, " in_ready_s"},  32'(rdy_s), 1);
    chk({tag, " out_valid_u"}, 32'(ov_u), 0);
    chk({tag, " out_valid_s"}, 32'(ov_s), 0);
    chk({tag, " out_last_u"},  32'(ol_u), 0);
    chk({tag, " out_last_s"},  32'(ol_s), 0);
    chk({tag, " busy_u"},      32'(bz_u), 0);
    chk({tag, " busy_s"},      32'(bz_s), 0);
    chk({tag, " out_data_u"},  32'(od_u), 0);
    chk({tag, " out_data_s"},  32'(od_s), 0);
  endtask

  task automatic load(input mat_t a, input mat_t b, input bit ragged, input string tag);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < NN && guard < 200) begin
      chk({tag, " load in_ready"}, 32'({rdy_u, rdy_s}), 3);
      if (ragged && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_a     = a[k];
        in_b     = b[k];
      end
      if (in_valid && rdy_u) k++;
      tick();
      guard++;
    end
    if (guard >= 200) chk({tag, " load timeout"}, 32'(k), NN);
    in_valid = ragged;
    in_a     = DW'($urandom);
    in_b     = DW'($urandom);
  endtask

  task automatic drain(input res_t eu, input res_t es, input bit ragged,
                       input int rmode, input string tag);
    int lat;
    int m;
    int c;
    int guard;
    lat = 0;
    m = 0;
    c = 0;
    guard = 0;
    while (!ov_u && lat < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      if (ragged) begin
        in_valid = 1'b1;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
      end
      tick();
      lat++;
    end
    chk({tag, " first out_valid latency"}, 32'(lat), N*N*N + 1);
    chk({tag, " signed out_valid with unsigned"}, 32'(ov_s), 1);
    while (m < NN && guard < 100) begin
      chk($sformatf("%s beat%0d valid", tag, m), 32'({ov_u, ov_s}), 3);
      chk($sformatf("%s beat%0d data_u", tag, m), 32'(od_u), 32'(eu[m]));
      chk($sformatf("%s beat%0d data_s", tag, m), 32'(od_s), 32'(es[m]));
      chk($sformatf("%s beat%0d last", tag, m), 32'({ol_u, ol_s}), (m == NN-1) ? 3 : 0);
      chk($sformatf("%s beat%0d in_ready", tag, m), 32'({rdy_u, rdy_s}), 0);
      chk($sformatf("%s beat%0d busy", tag, m), 32'({bz_u, bz_s}), 3);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (ragged) begin
        in_valid = 1'b1;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
      end
      if (ov_u && out_ready) m++;
      tick();
      c++;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (guard >= 100) chk({tag, " drain timeout"}, 32'(m), NN);
    chk({tag, " post out_valid"}, 32'({ov_u, ov_s}), 0);
    chk({tag, " post out_last"},  32'({ol_u, ol_s}), 0);
    chk({tag, " post busy"},      32'({bz_u, bz_s}), 0);
    chk({tag, " post in_ready"},  32'({rdy_u, rdy_s}), 3);
  endtask

  task automatic run_txn(input mat_t a, input mat_t b, input res_t eu, input res_t es,
                         input bit ragged, input int rmode, input string tag);
    load(a, b, ragged, tag);
    drain(eu, es, ragged, rmode, tag);
  endtask

  vec_t tbl [5];

  initial begin
    mat_t ra, rb;
    int   rmode;
    bit   rag;

    tbl[0].a = mk4(1, 2, 3, 4);     tbl[0].b = mk4(5, 6, 7, 8);
    tbl[0].eu = mk9(19, 22, 43, 50); tbl[0].es = mk9(19, -10, 43, -14);
    tbl[1].a = mk4(15, 15, 15, 15); tbl[1].b = mk4(15, 15, 15, 15);
    tbl[1].eu = mk9(450, 450, 450, 450); tbl[1].es = mk9(2, 2, 2, 2);
    tbl[2].a = mk4(-8, -8, -8, -8); tbl[2].b = mk4(-8, -8, -8, -8);
    tbl[2].eu = mk9(128, 128, 128, 128); tbl[2].es = mk9(128, 128, 128, 128);
    tbl[3].a = mk4(-1, 2, 3, -4);   tbl[3].b = mk4(1, 0, 0, 1);
    tbl[3].eu = mk9(15, 2, 3, 12);  tbl[3].es = mk9(-1, 2, 3, -4);
    tbl[4].a = mk4(0, 0, 0, 0);     tbl[4].b = mk4(9, 3, 7, 1);
    tbl[4].eu = mk9(0, 0, 0, 0);    tbl[4].es = mk9(0, 0, 0, 0);

    tick();
    tick();
    check_reset("in reset");
    rst_n = 1'b1;
    tick();
    check_reset("after release");

    for (int v = 0; v < 5; v++) begin
      run_txn(tbl[v].a, tbl[v].b, tbl[v].eu, tbl[v].es, 1'b0, 0, $sformatf("vec%0d", v));
    end

    // Back-pressure with out_ready pattern 1,0,0,1.
    run_txn(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es, 1'b0, 1, "backpressure");

    // Gappy in_valid during LOAD and garbage beats offered during COMPUTE/DRAIN.
    run_txn(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es, 1'b1, 0, "ragged");
    run_txn(tbl[3].a, tbl[3].b, tbl[3].eu, tbl[3].es, 1'b0, 0, "after ragged");

    // Asynchronous reset in the third COMPUTE cycle, away from any clock edge.
    load(tbl[0].a, tbl[0].b, 1'b0, "midreset");
    tick();
    tick();
    chk("midreset busy before", 32'({bz_u, bz_s}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset async");
    tick();
    tick();
    tick();
    check_reset("midreset held");
    rst_n = 1'b1;
    tick();
    check_reset("midreset released");
    run_txn(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es, 1'b0, 0, "post reset");

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < NN; k++) begin
        ra[k] = DW'($urandom);
        rb[k] = DW'($urandom);
      end
      rmode = int'($urandom_range(0, 2));
      rag   = 1'($urandom_range(0, 1));
      run_txn(ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), rag, rmode,
              $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1);
  end

endmodule
`default_nettype wire
